dmem_store_buffer_ctrl: RTL

- Memory-stage data-memory interface between the pipelined datapath's M-stage outputs (MemWriteM, ALUResultM, WriteDataM, ReadDataM) and a multi-cycle data memory using a req/ack handshake.
- Stores are posted into a DEPTH-entry write buffer, so they do not stall the pipeline unless the buffer is full.
- Loads hit in the buffer through store-to-load forwarding or issue a read to memory. A load miss raises StallM, which the hazard unit ORs into StallF/StallD/StallE/StallM.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/store_buffer.sv | 85 ++++++++
 rtl/dmem_store_buffer_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store-buffer controller.
//   dmem_state_t : memory-port FSM states
//   wb_entry_t   : one write-buffer slot (valid, word address, data)
//   WORD_LSB     : lowest address bit that takes part in word compares
package dmem_pkg;

    localparam int unsigned WORD_LSB    = 2;
    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY,
        RD_DONE
    } dmem_state_t;

    typedef struct packed {
        logic                            valid;
        logic [DMEM_ADDR_W-1:WORD_LSB]   addr;
        logic [DMEM_DATA_W-1:0]          data;
    } wb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// Circular write buffer with a parallel youngest-match lookup.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   enq, enq_addr/data    : push a store at the tail (ignored when full)
//   deq                   : pop the head (ignored when empty)
//   count, full, empty    : occupancy
//   head_addr, head_data  : oldest entry, drives the memory write
//   lookup_addr           : load word address to search for
//   hit, hit_data         : youngest valid entry matching lookup_addr
module store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq,
    input  logic [ADDR_W-1:WORD_LSB] enq_addr,
    input  logic [DATA_W-1:0]        enq_data,
    input  logic                     deq,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_W-1:WORD_LSB] head_addr,
    output logic [DATA_W-1:0]        head_data,
    input  logic [ADDR_W-1:WORD_LSB] lookup_addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        hit_data
);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_enq;
    logic             do_deq;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;

    assign head_addr = entries[head].addr;
    assign head_data = entries[head].data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (do_enq) begin
                entries[tail].valid <= 1'b1;
                entries[tail].addr  <= enq_addr;
                entries[tail].data  <= enq_data;
                tail                <= tail + PTR_W'(1);
            end
            if (do_deq) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            automatic logic [PTR_W-1:0] idx = head + PTR_W'(i);
            if (entries[idx].valid && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer_ctrl.sv
// M-stage data-memory interface: posts stores into a write buffer, forwards
// buffered data to loads, and runs a req/ack memory port for drains and
// load misses.
// Ports:
//   clk, reset                       : clock, synchronous active-low reset
//   MemWriteM, MemReadM              : qualified store / load this cycle
//   ALUResultM, WriteDataM           : byte address, store data
//   ReadDataM                        : load data (valid when !StallM)
//   StallM                           : hold the pipeline
//   wb_empty                         : buffer empty and port idle
//   mem_req/we/addr/wdata            : registered memory request
//   mem_ack, mem_rdata               : memory completion and read data
module dmem_store_buffer_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              wb_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dmem_state_t              state, state_nx;
    logic                     req_nx, we_nx;
    logic [ADDR_W-1:0]        addr_nx;
    logic [DATA_W-1:0]        wdata_nx;
    logic [DATA_W-1:0]        rd_data, rd_data_nx;

    logic                     load_req, load_miss;
    logic                     enq, deq;
    logic                     hit, full, empty;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W-1:WORD_LSB] head_addr;
    logic [DATA_W-1:0]        head_data, hit_data;

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store_buffer (
        .clk         (clk),
        .reset       (reset),
        .enq         (enq),
        .enq_addr    (ALUResultM[ADDR_W-1:WORD_LSB]),
        .enq_data    (WriteDataM),
        .deq         (deq),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .lookup_addr (ALUResultM[ADDR_W-1:WORD_LSB]),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // A simultaneous store and load is illegal; the store takes precedence.
    assign load_req  = MemReadM && !MemWriteM;
    assign load_miss = load_req && !hit;
    assign enq       = MemWriteM && (state != RD_BUSY) && !full;
    assign wb_empty  = (count == '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_data   <= '0;
        end else begin
            state     <= state_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            rd_data   <= rd_data_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_nx     = mem_req;
        we_nx      = mem_we;
        addr_nx    = mem_addr;
        wdata_nx   = mem_wdata;
        rd_data_nx = rd_data;
        deq        = 1'b0;
        StallM     = MemWriteM && !enq;
        ReadDataM  = '0;

        unique case (state)
            IDLE: begin
                if (load_req && hit) begin
                    ReadDataM = hit_data;
                end
                // Load misses take the port ahead of buffer drains.
                if (load_miss) begin
                    StallM   = 1'b1;
                    state_nx = RD_BUSY;
                    req_nx   = 1'b1;
                    we_nx    = 1'b0;
                    addr_nx  = ALUResultM;
                end else if (!empty) begin
                    state_nx = WR_BUSY;
                    req_nx   = 1'b1;
                    we_nx    = 1'b1;
                    addr_nx  = {head_addr, {WORD_LSB{1'b0}}};
                    wdata_nx = head_data;
                end
            end
            WR_BUSY: begin
                if (load_req && hit) begin
                    ReadDataM = hit_data;
                end
                if (load_miss) begin
                    StallM = 1'b1;
                end
                // A miss waiting on the drain issues its read straight off
                // the write ack, without a detour through IDLE.
                if (mem_ack) begin
                    deq = 1'b1;
                    if (load_miss) begin
                        state_nx = RD_BUSY;
                        req_nx   = 1'b1;
                        we_nx    = 1'b0;
                        addr_nx  = ALUResultM;
                    end else begin
                        state_nx = IDLE;
                        req_nx   = 1'b0;
                    end
                end
            end
            RD_BUSY: begin
                StallM = 1'b1;
                if (mem_ack) begin
                    rd_data_nx = mem_rdata;
                    state_nx   = RD_DONE;
                    req_nx     = 1'b0;
                end
            end
            RD_DONE: begin
                if (load_req) begin
                    ReadDataM = rd_data;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assert property (@(posedge clk) disable iff (!reset) !(MemWriteM && MemReadM));

endmodule
